// File: rtl/axi_pkg.sv
// Shared AXI3 types for the SRAM responder: ID/length/size/burst/response
// encodings and the responder state enum.
package axi_pkg;

  typedef logic [3:0] axi_id_t;
  typedef logic [3:0] axi_len_t;
  typedef logic [2:0] axi_size_t;

  typedef enum logic [1:0] {
    BURST_FIXED = 2'b00,
    BURST_INCR  = 2'b01,
    BURST_WRAP  = 2'b10,
    BURST_RSVD  = 2'b11
  } axi_burst_t;

  typedef enum logic [1:0] {
    RESP_OKAY   = 2'b00,
    RESP_EXOKAY = 2'b01,
    RESP_SLVERR = 2'b10,
    RESP_DECERR = 2'b11
  } axi_resp_t;

  typedef enum logic [1:0] {
    S_IDLE,
    S_READ,
    S_WRITE,
    S_WRESP
  } slv_state_e;

endpackage

// File: rtl/axi_burst_addr_gen.sv
// Per-beat AXI address sequencer: given the current beat address and the
// latched burst attributes, produces the next beat address. Reserved bursts
// and WRAP with an unsupported length fall back to INCR and raise illegal_o.
module axi_burst_addr_gen
  import axi_pkg::*;
(
  input  logic [31:0] addr_i,
  input  axi_size_t   size_i,
  input  axi_len_t    len_i,
  input  axi_burst_t  burst_i,
  output logic [31:0] next_addr_o,
  output logic        illegal_o
);

  logic [31:0] step;
  logic [31:0] container;
  logic [31:0] mask;
  logic        wrap_len_ok;

  // Next-address computation for FIXED / INCR / WRAP
  always_comb begin
    step        = 32'd1 << size_i;
    container   = ({28'd0, len_i} + 32'd1) << size_i;
    mask        = container - 32'd1;
    wrap_len_ok = (len_i == 4'd1) || (len_i == 4'd3) ||
                  (len_i == 4'd7) || (len_i == 4'd15);
    illegal_o   = (burst_i == BURST_RSVD) ||
                  ((burst_i == BURST_WRAP) && !wrap_len_ok);
    next_addr_o = addr_i + step;
    case (burst_i)
      BURST_FIXED: next_addr_o = addr_i;
      BURST_WRAP: begin
        if (wrap_len_ok) begin
          next_addr_o = (addr_i & ~mask) | ((addr_i + step) & mask);
        end
      end
      default: ;
    endcase
  end

endmodule

// File: rtl/axi_sram_slave.sv
// AXI3 single-outstanding responder over a byte-writable 32-bit word RAM.
// Optional build macro AXI_SLAVE_RANDOM_STALL_EN enables LFSR-driven
// back-pressure on the ready outputs and deferral of new valids.
module axi_sram_slave
  import axi_pkg::*;
#(
  parameter int          MEM_AW     = 12,
  parameter              INIT_FILE  = "",
  parameter logic [15:0] STALL_SEED = 16'hACE1
) (
  input  logic        clk,
  input  logic        reset,
  input  logic [3:0]  arid,
  input  logic [31:0] araddr,
  input  logic [3:0]  arlen,
  input  logic [2:0]  arsize,
  input  logic [1:0]  arburst,
  input  logic [1:0]  arlock,
  input  logic [3:0]  arcache,
  input  logic [2:0]  arprot,
  input  logic        arvalid,
  output logic        arready,
  output logic [3:0]  rid,
  output logic [31:0] rdata,
  output logic [1:0]  rresp,
  output logic        rlast,
  output logic        rvalid,
  input  logic        rready,
  input  logic [3:0]  awid,
  input  logic [31:0] awaddr,
  input  logic [3:0]  awlen,
  input  logic [2:0]  awsize,
  input  logic [1:0]  awburst,
  input  logic [1:0]  awlock,
  input  logic [3:0]  awcache,
  input  logic [2:0]  awprot,
  input  logic        awvalid,
  output logic        awready,
  input  logic [3:0]  wid,
  input  logic [31:0] wdata,
  input  logic [3:0]  wstrb,
  input  logic        wlast,
  input  logic        wvalid,
  output logic        wready,
  output logic [3:0]  bid,
  output logic [1:0]  bresp,
  output logic        bvalid,
  input  logic        bready
);

  localparam int DEPTH = 1 << MEM_AW;

  logic [31:0] mem [DEPTH];

  slv_state_e  state_q, state_d;
  axi_id_t     id_q, id_d;
  logic [31:0] addr_q, addr_d;
  axi_len_t    len_q, len_d;
  axi_size_t   size_q, size_d;
  axi_burst_t  burst_q, burst_d;
  logic [4:0]  beat_q, beat_d;
  axi_resp_t   bresp_q, bresp_d;
  logic        rv_q, rv_d;
  logic        bv_q, bv_d;
  logic [31:0] rdata_q;

  logic              rd_en;
  logic [MEM_AW-1:0] rd_idx;
  logic              wr_en;
  logic [31:0]       next_addr;
  logic              illegal;
  logic              stall;
  logic              last_beat;
  logic              unused_ok;

  assign unused_ok = ^{arlock, arcache, arprot, awlock, awcache, awprot, wid};

`ifdef AXI_SLAVE_RANDOM_STALL_EN
  logic [15:0] lfsr_q;

  // Fibonacci LFSR (taps 16,14,13,11) supplying pseudo-random back-pressure
  always_ff @(posedge clk) begin
    if (reset) begin
      lfsr_q <= STALL_SEED;
    end else begin
      lfsr_q <= {lfsr_q[14:0], lfsr_q[15] ^ lfsr_q[13] ^ lfsr_q[12] ^ lfsr_q[10]};
    end
  end

  assign stall = lfsr_q[0];
`else
  localparam logic [15:0] UNUSED_STALL_SEED = STALL_SEED;
  assign stall = 1'b0;
`endif

  axi_burst_addr_gen u_addr_gen (
    .addr_i      (addr_q),
    .size_i      (size_q),
    .len_i       (len_q),
    .burst_i     (burst_q),
    .next_addr_o (next_addr),
    .illegal_o   (illegal)
  );

  // Handshake outputs are forced low during reset; a valid that has already
  // been shown (rv_q/bv_q) ignores stall so it is never withdrawn.
  assign last_beat = (beat_q == {1'b0, len_q});
  assign arready   = !reset && (state_q == S_IDLE) && !stall;
  assign awready   = arready && !arvalid;
  assign wready    = !reset && (state_q == S_WRITE) && !stall;
  assign rvalid    = !reset && (state_q == S_READ) && (rv_q || !stall);
  assign bvalid    = !reset && (state_q == S_WRESP) && (bv_q || !stall);
  assign rid       = (!reset && state_q == S_READ) ? id_q : '0;
  assign rdata     = (!reset && state_q == S_READ) ? rdata_q : '0;
  assign rresp     = (!reset && state_q == S_READ && illegal) ? RESP_SLVERR : RESP_OKAY;
  assign rlast     = !reset && (state_q == S_READ) && last_beat;
  assign bid       = (!reset && state_q == S_WRESP) ? id_q : '0;
  assign bresp     = (!reset && state_q == S_WRESP) ? bresp_q : RESP_OKAY;

  // Next-state logic: channel arbitration, beat counting, RAM port control
  always_comb begin
    state_d = state_q;
    id_d    = id_q;
    addr_d  = addr_q;
    len_d   = len_q;
    size_d  = size_q;
    burst_d = burst_q;
    beat_d  = beat_q;
    bresp_d = bresp_q;
    rv_d    = rv_q;
    bv_d    = bv_q;
    rd_en   = 1'b0;
    rd_idx  = araddr[MEM_AW+1:2];
    wr_en   = 1'b0;
    case (state_q)
      S_IDLE: begin
        if (arvalid && arready) begin
          id_d    = arid;
          addr_d  = araddr;
          len_d   = arlen;
          size_d  = arsize;
          burst_d = axi_burst_t'(arburst);
          beat_d  = '0;
          rv_d    = 1'b0;
          rd_en   = 1'b1;
          state_d = S_READ;
        end else if (awvalid && awready) begin
          id_d    = awid;
          addr_d  = awaddr;
          len_d   = awlen;
          size_d  = awsize;
          burst_d = axi_burst_t'(awburst);
          beat_d  = '0;
          state_d = S_WRITE;
        end
      end
      S_READ: begin
        rv_d = rv_q | rvalid;
        if (rvalid && rready) begin
          if (last_beat) begin
            rv_d    = 1'b0;
            state_d = S_IDLE;
          end else begin
            addr_d = next_addr;
            beat_d = beat_q + 5'd1;
            rd_en  = 1'b1;
            rd_idx = next_addr[MEM_AW+1:2];
          end
        end
      end
      S_WRITE: begin
        if (wvalid && wready) begin
          wr_en  = (beat_q <= {1'b0, len_q});
          addr_d = next_addr;
          if (beat_q != 5'd31) begin
            beat_d = beat_q + 5'd1;
          end
          if (wlast) begin
            bv_d    = 1'b0;
            bresp_d = ((beat_d == {1'b0, len_q} + 5'd1) && !illegal) ? RESP_OKAY : RESP_SLVERR;
            state_d = S_WRESP;
          end
        end
      end
      S_WRESP: begin
        bv_d = bv_q | bvalid;
        if (bvalid && bready) begin
          bv_d    = 1'b0;
          state_d = S_IDLE;
        end
      end
      default: state_d = S_IDLE;
    endcase
  end

  // Control registers: FSM state and valid-shown flags
  always_ff @(posedge clk) begin
    if (reset) begin
      state_q <= S_IDLE;
      rv_q    <= 1'b0;
      bv_q    <= 1'b0;
    end else begin
      state_q <= state_d;
      rv_q    <= rv_d;
      bv_q    <= bv_d;
    end
  end

  // Latched transaction attributes and beat counter
  always_ff @(posedge clk) begin
    id_q    <= id_d;
    addr_q  <= addr_d;
    len_q   <= len_d;
    size_q  <= size_d;
    burst_q <= burst_d;
    beat_q  <= beat_d;
    bresp_q <= bresp_d;
  end

  // Word RAM: byte-lane writes and synchronous read into the R data register
  always_ff @(posedge clk) begin
    if (wr_en) begin
      for (int b = 0; b < 4; b++) begin
        if (wstrb[b]) begin
          mem[addr_q[MEM_AW+1:2]][8*b +: 8] <= wdata[8*b +: 8];
        end
      end
    end
    if (rd_en) begin
      rdata_q <= mem[rd_idx];
    end
  end

endmodule
